// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, 3-sample majority-vote bit sampler,
// LSB-first deserializer, and parity and stop checking.
// The external edge/bit counter runs while cnt_enable is high and clears while it is low.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [7:0]            prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [15:0]           edge_count,
    input  logic [3:0]            bit_count,
    output logic                  cnt_enable,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e                state_q, state_d;
    logic                  cfg_pe_q, cfg_pe_d;
    logic                  cfg_pt_q, cfg_pt_d;
    logic                  s0_q, s0_d;
    logic                  s1_q, s1_d;
    logic                  s2_q, s2_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic                  perr_q, perr_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  dv_q, dv_d;
    logic                  pe_q, pe_d;
    logic                  se_q, se_d;

    logic [15:0] pre_w;
    logic [15:0] half_w;
    logic        bit_end;
    logic        bit_s;

    assign pre_w   = {8'h00, prescale};
    assign half_w  = {9'h000, prescale[7:1]};
    assign bit_end = (edge_count == pre_w - 16'd1);
    assign bit_s   = (s0_q & s1_q) | (s0_q & s2_q) | (s1_q & s2_q);

    // Next-state, sampling, shift and output-pulse logic; decisions are taken only at bit_end
    always_comb begin
        state_d  = state_q;
        cfg_pe_d = cfg_pe_q;
        cfg_pt_d = cfg_pt_q;
        s0_d     = s0_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        sr_d     = sr_q;
        perr_d   = perr_q;
        p_data_d = p_data_q;
        dv_d     = 1'b0;
        pe_d     = 1'b0;
        se_d     = 1'b0;

        if (state_q != IDLE) begin
            if (edge_count == half_w - 16'd1) s0_d = rx_in;
            if (edge_count == half_w)         s1_d = rx_in;
            if (edge_count == half_w + 16'd1) s2_d = rx_in;
        end

        case (state_q)
            IDLE: begin
                if (!rx_in) begin
                    state_d  = START;
                    cfg_pe_d = par_en;
                    cfg_pt_d = par_typ;
                    perr_d   = 1'b0;
                end
            end
            START: begin
                if (bit_end) state_d = bit_s ? IDLE : DATA;
            end
            DATA: begin
                if (bit_end) begin
                    sr_d = {bit_s, sr_q[DATA_WIDTH-1:1]};
                    if (bit_count == LAST_DATA_BIT) state_d = cfg_pe_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    perr_d  = bit_s ^ (cfg_pt_q ? ~^sr_q : ^sr_q);
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    if (!bit_s) se_d = 1'b1;
                    if (perr_q) pe_d = 1'b1;
                    if (bit_s && !perr_q) begin
                        p_data_d = sr_q;
                        dv_d     = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered output pulses; asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cfg_pe_q <= 1'b0;
            cfg_pt_q <= 1'b0;
            s0_q     <= 1'b0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            sr_q     <= '0;
            perr_q   <= 1'b0;
            p_data_q <= '0;
            dv_q     <= 1'b0;
            pe_q     <= 1'b0;
            se_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_pe_q <= cfg_pe_d;
            cfg_pt_q <= cfg_pt_d;
            s0_q     <= s0_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            sr_q     <= sr_d;
            perr_q   <= perr_d;
            p_data_q <= p_data_d;
            dv_q     <= dv_d;
            pe_q     <= pe_d;
            se_q     <= se_d;
        end
    end

    assign cnt_enable = (state_q != IDLE);
    assign p_data     = p_data_q;
    assign data_valid = dv_q;
    assign par_err    = pe_q;
    assign stp_err    = se_q;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
UART receive controller that sits directly downstream of the RX edge/bit counter. It drives that counter's enable input and consumes its edge_count/bit_count outputs. It contains the frame FSM, a 3-sample majority-vote bit sampler, an LSB-first deserializer and parity/stop checking. It presents one received byte per frame with a one-cycle valid pulse to the RX-side consumer.

Parameters:
DATA_WIDTH, 8, data bits per frame; supported range 5..8 (frame length must fit the 4-bit bit_count).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  asynchronous active-low reset.
rx_in  input  1  serial line, idle high, already synchronized to clk upstream.
prescale  input  8  clocks per bit; legal values even and >= 8 (8/16/32 in practice); static during a frame.
par_en  input  1  1 = parity bit present.
par_typ  input  1  0 = even, 1 = odd.
edge_count  input  16  from counter: clocks elapsed in current bit, 0..prescale-1.
bit_count  input  4  from counter: bit index in frame, start = 0.
cnt_enable  output  1  counter enable; counter clears while low.
p_data  output  DATA_WIDTH  last good byte, bit 0 = first data bit received.
data_valid  output  1  one-cycle pulse, p_data updated.
par_err  output  1  one-cycle pulse, parity mismatch.
stp_err  output  1  one-cycle pulse, stop bit sampled 0.

Behaviour:
- Reset (asynchronous, rst low): state IDLE; cnt_enable, data_valid, par_err, stp_err = 0; p_data = 0; shift register and samples cleared. Reset mid-frame abandons the frame with no pulses.
- cnt_enable = (state != IDLE), decoded from the registered state.
- half = prescale >> 1. Samples s0/s1/s2 are registered when edge_count == half-1, half, half+1. bit_s = majority(s0, s1, s2).
- "bit_end" = (edge_count == prescale-1). All decisions are taken on the bit_end clock edge.
- FSM:
  - IDLE: if rx_in == 0, go to START and latch par_en/par_typ into frame config. The cycle in which rx_in is first seen low is T0.
  - START: at bit_end, go to DATA if bit_s == 0; otherwise go to IDLE as a glitch (no pulses, counter clears because enable drops).
  - DATA: at bit_end, shift sr <= {bit_s, sr[DATA_WIDTH-1:1]}. When bit_count == DATA_WIDTH, go to PARITY if the latched par_en is set, else STOP.
  - PARITY: at bit_end, perr <= bit_s XOR (latched par_typ ? ~^sr : ^sr), then go to STOP.
  - STOP: at bit_end, go to IDLE. If bit_s == 0, pulse stp_err. If perr, pulse par_err. If neither, p_data <= sr and pulse data_valid.
- All output pulses are registered on the STOP bit_end edge and last exactly one cycle.
- p_data holds its value on any error.
- Latency, no parity: pulses high in cycle T0 + 1 + (DATA_WIDTH + 2) * prescale. With parity, add prescale.
- Back-to-back frames: the FSM returns to IDLE for at least one cycle (counter clears). A start edge already present in that cycle is accepted; an edge arriving mid-stop is seen on the first IDLE cycle.
- par_en/par_typ changes mid-frame have no effect until the next frame. prescale changes mid-frame are illegal (undefined result).
- An rx_in glitch inside a data bit that affects only one of the three samples is rejected by the majority vote.

Test Plan:
1. prescale = 8, par_en = 0, byte 0xA5, stop = 1 -> data_valid high only in cycle T0+81; p_data = 0xA5; par_err = stp_err = 0; cnt_enable low from T0+81.
2. prescale = 16, par_en = 1, par_typ = 0, byte 0x3C with parity bit 0 -> data_valid at T0+177, p_data = 0x3C. Repeat with parity bit 1 -> par_err pulse at T0+177, no data_valid, p_data stays 0x3C.
3. prescale = 8, par_typ = 1, byte 0x01 with parity bit 0 -> data_valid, p_data = 0x01. Then byte 0x55 with stop bit 0 -> stp_err pulse only, p_data stays 0x01.
4. prescale = 8, rx_in low for 2 cycles only -> FSM returns to IDLE after 8 cycles (cnt_enable low at T0+9); no pulses. A following valid frame 0x5A is received correctly.
5. Two back-to-back frames 0x12, 0x34 with a new start bit immediately after each stop bit, prescale = 8 -> two data_valid pulses with the correct bytes, no errors.
6. rst asserted during DATA bit 4 -> all outputs 0 and cnt_enable 0 immediately. After release, frame 0xC3 is received with data_valid and p_data = 0xC3.
